// File: rtl/booth_seq_ctrl_pkg.sv
// Shared definitions for the sequential Booth multiplier controller.
//   state_e  : controller FSM encodings (IDLE/RUN/DONE; the unused code 2'd3
//              is steered back to IDLE by the controller).
//   op_e     : Booth recoding operations applied to the accumulator.
//   booth_op : maps the multiplier bit pair {q[0], q_m1} to an operation.
package booth_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } op_e;

  // 01 -> end of a run of ones: add m; 10 -> start of a run: subtract m.
  function automatic op_e booth_op(input logic i_q0, input logic i_qm1);
    case ({i_q0, i_qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// W-bit two's complement adder/subtractor built from 4-bit carry-lookahead
// slices with the slice carries rippled between slices.
// Ports:
//   a   in  W  signed left operand
//   b   in  W  signed right operand
//   sub in  1  1: y = a - b (a + ~b + 1), 0: y = a + b
//   y   out W  signed result; the final carry-out is discarded
module booth_addsub #(
  parameter int W = 9
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);

  localparam int NS = (W + 3) / 4;
  localparam int NW = NS * 4;

  // Operands are sign-extended to a whole number of slices.
  logic [NW-1:0] w_a;
  logic [NW-1:0] w_b;
  logic [NW-1:0] w_s;
  logic          w_cout;
  logic          w_unused;

  assign w_a = NW'(a);
  assign w_b = sub ? ~NW'(b) : NW'(b);

  always_comb begin : cla
    logic [3:0] v_g;
    logic [3:0] v_p;
    logic [3:0] v_c;
    logic       v_ci;
    w_s  = '0;
    v_g  = '0;
    v_p  = '0;
    v_c  = '0;
    v_ci = sub;
    for (int i = 0; i < NS; i++) begin
      v_g    = w_a[4*i +: 4] & w_b[4*i +: 4];
      v_p    = w_a[4*i +: 4] ^ w_b[4*i +: 4];
      v_c[0] = v_ci;
      v_c[1] = v_g[0] | (v_p[0] & v_ci);
      v_c[2] = v_g[1] | (v_p[1] & v_g[0]) | (v_p[1] & v_p[0] & v_ci);
      v_c[3] = v_g[2] | (v_p[2] & v_g[1]) | (v_p[2] & v_p[1] & v_g[0])
             | (v_p[2] & v_p[1] & v_p[0] & v_ci);
      v_ci   = v_g[3] | (v_p[3] & v_g[2]) | (v_p[3] & v_p[2] & v_g[1])
             | (v_p[3] & v_p[2] & v_p[1] & v_g[0]) | ((&v_p) & v_ci);
      w_s[4*i +: 4] = v_p ^ v_c;
    end
    w_cout = v_ci;
  end

  assign y = w_s[W-1:0];

  // Sign-extension bits above W and the carry-out have no consumer.
  assign w_unused = ^{w_s, w_cout};

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller. One shared (WIDTH+1)-bit
// add/sub is stepped once per cycle over the WIDTH multiplier bits.
// Ports:
//   clk       in   1         rising-edge clock
//   rst_n     in   1         synchronous active-low reset
//   in_valid  in   1         operands a, b valid
//   in_ready  out  1         operands accepted (IDLE only)
//   a         in   WIDTH     signed multiplicand
//   b         in   WIDTH     signed multiplier
//   out_valid out  1         product valid (DONE)
//   out_ready in   1         consumer accepts product
//   y         out  2*WIDTH   signed product, 0 when out_valid is low
//   busy      out  1         high in RUN and DONE
module booth_seq_ctrl
  import booth_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] y,
  output logic                      busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic signed [WIDTH:0]   r_acc;
  logic signed [WIDTH:0]   r_m;
  logic        [WIDTH-1:0] r_q;
  logic                    r_qm1;
  logic        [CNT_W-1:0] r_cnt;
  logic signed [WIDTH:0]   w_addsub_y;
  logic signed [WIDTH:0]   w_sum;
  op_e                     w_op;
  logic                    w_last;

  assign w_op   = booth_op(r_q[0], r_qm1);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  booth_addsub #(.W(WIDTH + 1)) u_addsub (
    .a   (r_acc),
    .b   (r_m),
    .sub (w_op == OP_SUB),
    .y   (w_addsub_y)
  );

  assign w_sum = (w_op == OP_NOP) ? r_acc : w_addsub_y;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load on accept, then one add/sub + arithmetic shift of {acc,q,q_m1}
  // per RUN cycle. Registers are left untouched in DONE so y holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_m   <= '0;
      r_q   <= '0;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && in_valid) begin
      r_acc <= '0;
      r_m   <= {a[WIDTH-1], a};
      r_q   <= b;
      r_qm1 <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
      r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      r_qm1 <= r_q[0];
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign y = out_valid ? {r_acc[WIDTH-1:0], r_q} : '0;

endmodule
